mp_regfile_sb: RTL and testbench
================================

Name: mp_regfile_sb

Overview:
- Parametrised multi-port integer register file: NUM_WR write ports, NUM_RD read ports, with a per-register pending scoreboard.
- Successor to the fixed dual-write regfile. Adds:
  - generic port counts;
  - deterministic write-conflict priority;
  - a post-reset clear sequencer;
  - reserve/complete tracking for in-flight results.
- Sits between decode/issue (reads, reservations) and the writeback stages (writes).

Parameters:
- ADDR_W, 5, register address width; 2**ADDR_W entries, entry 0 hardwired to zero.
- DATA_W, 32, register data width.
- NUM_WR, 2, number of write ports (1..4).
- NUM_RD, 2, number of read ports (1..4).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- wr_en  input  NUM_WR  per-port write enable.
- wr_addr  input  NUM_WR*ADDR_W  write addresses, port k at bits [k*ADDR_W +: ADDR_W].
- wr_data  input  NUM_WR*DATA_W  write data, packed the same way.
- rd_addr  input  NUM_RD*ADDR_W  read addresses.
- rd_data  output  NUM_RD*DATA_W  read data, combinational from the array.
- rd_pending  output  NUM_RD  pending bit of the addressed register.
- rsv_en  input  1  reserve request: mark rsv_addr as awaiting a write.
- rsv_addr  input  ADDR_W  register to reserve.
- init_done  output  1  high once the clear sequence has finished.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state <= INIT, clear counter <= 1, all pending bits <= 0, init_done <= 0.
  - The data array itself has no reset.
- State machine:
  - INIT: each cycle writes 0 to entry[counter], then increments counter. When counter reaches 2**ADDR_W-1 and that entry is written, go to READY. INIT lasts exactly 2**ADDR_W-1 cycles after reset release.
  - READY: init_done = 1. Stays in READY until the next reset.
- During INIT:
  - wr_en and rsv_en are ignored.
  - rd_data = 0 and rd_pending = 0 on all ports.
- Reset asserted mid-INIT or mid-READY: immediate return to INIT with counter = 1; the full clear sequence restarts.
- Writes (READY only):
  - Port k with wr_en[k]=1 and wr_addr != 0 updates the entry on the next rising edge.
  - Writes to address 0 are dropped.
  - Several ports targeting the same address in one cycle: the highest-index port wins. Lower-index data is discarded.
- Reads:
  - rd_data = 0 when rd_addr = 0; otherwise the current array contents.
  - Write-then-read latency is 1 cycle: a write at edge N is visible after edge N.
  - rd_pending = pending[rd_addr]. pending[0] is always 0.
- Scoreboard (READY only):
  - rsv_en=1 with rsv_addr != 0 sets pending[rsv_addr] at the next edge.
  - Any accepted write to address A clears pending[A] at the next edge.
  - Reserve and write to the same address in the same cycle: the reserve wins and pending stays or becomes 1, since a newer producer was issued.
  - Reserving an already-pending register keeps it 1. Writing a non-pending register leaves it 0.
- Width rules: port-index and address arithmetic are unsigned. The counter is ADDR_W bits, and wrap-around is never reached because INIT exits at its maximum value.

Optional Feature:
- Macro: MP_REGFILE_BYPASS_EN.
- Defined:
  - A read whose address matches an accepted same-cycle write (READY, wr_en=1, addr != 0) returns that wr_data combinationally.
  - When several write ports match, the highest-index port supplies the data.
  - rd_pending on that port reads 0 in that cycle, unless rsv_en targets the same address, in which case it reads 1.
- Not defined: reads return array contents only, so 1-cycle write-to-read latency; rd_pending reflects registered state only.

Test Plan:
- Reset release with ADDR_W=5 -> init_done low for exactly 31 cycles, then high; reads of r1..r31 return 0x00000000 and pending 0.
- wr_en=2'b11, both ports addr 7, data 0xAAAA0000 (port0) / 0x5555FFFF (port1) -> next cycle r7 reads 0x5555FFFF.
- Write 0xDEADBEEF to addr 0 -> rd_addr 0 returns 0; rsv_addr 0 -> rd_pending 0.
- rsv_en addr 5 -> pending[5]=1 next cycle; later wr port0 addr 5 data 0x12 -> pending 0 and r5=0x12 next cycle; then rsv_en plus write to addr 5 in the same cycle -> pending stays 1.
- In READY: write r3=0x1; assert rst_n low for 1 cycle mid-stream -> init_done drops, writes during the next 31 cycles are ignored, r3 reads 0 afterwards.
- With MP_REGFILE_BYPASS_EN: write addr 9 data 0xCAFE while rd_addr 9 in the same cycle -> rd_data 0xCAFE that cycle. Without the macro -> old value that cycle, 0xCAFE the next cycle.

Source files
------------

// File: rtl/mp_regfile_sb_if.sv
// Bundles the multi-port register file's write, read and reserve signals.
// master drives requests (issue/writeback side); slave is the register file.
interface mp_regfile_sb_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int NUM_WR = 2,
  parameter int NUM_RD = 2
);
  logic [NUM_WR-1:0]        wr_en;
  logic [NUM_WR*ADDR_W-1:0] wr_addr;
  logic [NUM_WR*DATA_W-1:0] wr_data;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_pending;
  logic                     rsv_en;
  logic [ADDR_W-1:0]        rsv_addr;
  logic                     init_done;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr, rsv_en, rsv_addr,
    input  rd_data, rd_pending, init_done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr, rsv_en, rsv_addr,
    output rd_data, rd_pending, init_done
  );
endinterface

// File: rtl/mp_regfile_sb.sv
// Multi-port register file with a post-reset clear sequencer and a pending scoreboard.
// Optional macro MP_REGFILE_BYPASS_EN forwards same-cycle writes to the read ports.
module mp_regfile_sb #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int NUM_WR = 2,
  parameter int NUM_RD = 2
) (
  input logic             clk,
  input logic             rst_n,
  mp_regfile_sb_if.slave  rf
);
  localparam int unsigned NREG = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = '1;

  typedef enum logic {ST_INIT, ST_READY} state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  cnt_q, cnt_d;
  logic [NREG-1:0]    pend_q, pend_d;
  logic [DATA_W-1:0]  mem_q [NREG];

  logic               ready;
  logic [ADDR_W-1:0]  wa [NUM_WR];
  logic [DATA_W-1:0]  wd [NUM_WR];
  logic [NUM_WR-1:0]  wv;
  logic               rsv_ok;

  assign ready        = (state_q == ST_READY);
  assign rf.init_done = ready;
  assign rsv_ok       = ready && rf.rsv_en && (rf.rsv_addr != '0);

  always_comb begin
    for (int unsigned k = 0; k < NUM_WR; k++) begin
      wa[k] = rf.wr_addr[k*ADDR_W +: ADDR_W];
      wd[k] = rf.wr_data[k*DATA_W +: DATA_W];
      wv[k] = ready && rf.wr_en[k] && (wa[k] != '0);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_INIT) begin
      if (cnt_q == LAST) begin
        state_d = ST_READY;
      end else begin
        cnt_d = cnt_q + ADDR_W'(1);
      end
    end
  end

  // Reserve is applied after the write clears so a newer producer keeps the bit set.
  always_comb begin
    pend_d = pend_q;
    for (int unsigned k = 0; k < NUM_WR; k++) begin
      if (wv[k]) pend_d[wa[k]] = 1'b0;
    end
    if (rsv_ok) pend_d[rf.rsv_addr] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= ADDR_W'(1);
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  // Later loop iterations override earlier ones, giving highest-index port priority.
  always_ff @(posedge clk) begin
    if (!ready) begin
      mem_q[cnt_q] <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_WR; k++) begin
        if (wv[k]) mem_q[wa[k]] <= wd[k];
      end
    end
  end

  always_comb begin
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;
    logic              rp;
    rf.rd_data    = '0;
    rf.rd_pending = '0;
    for (int unsigned j = 0; j < NUM_RD; j++) begin
      ra = rf.rd_addr[j*ADDR_W +: ADDR_W];
      rd = '0;
      rp = 1'b0;
      if (ready && (ra != '0)) begin
        rd = mem_q[ra];
        rp = pend_q[ra];
`ifdef MP_REGFILE_BYPASS_EN
        for (int unsigned k = 0; k < NUM_WR; k++) begin
          if (wv[k] && (wa[k] == ra)) begin
            rd = wd[k];
            rp = rsv_ok && (rf.rsv_addr == ra);
          end
        end
`endif
      end
      rf.rd_data[j*DATA_W +: DATA_W] = rd;
      rf.rd_pending[j]               = rp;
    end
  end
endmodule

// File: tb/tb_mp_regfile_sb.sv
// Self-checking bench for mp_regfile_sb: directed scenarios plus random traffic
// against an array-based reference model.
module tb_mp_regfile_sb;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NW = 2;
  localparam int NR = 2;
  localparam int NREG = 2 ** AW;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  logic [DW-1:0] m_mem [NREG];
  logic [NREG-1:0] m_pend;
  logic m_ready;
  int   m_cnt;

  mp_regfile_sb_if #(.ADDR_W(AW), .DATA_W(DW), .NUM_WR(NW), .NUM_RD(NR)) rf ();

  mp_regfile_sb #(.ADDR_W(AW), .DATA_W(DW), .NUM_WR(NW), .NUM_RD(NR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rf    (rf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < NREG; i++) m_mem[i] = '0;
    m_pend  = '0;
    m_ready = 1'b0;
    m_cnt   = 0;
  endtask

  task automatic idle();
    rf.wr_en    = '0;
    rf.wr_addr  = '0;
    rf.wr_data  = '0;
    rf.rsv_en   = 1'b0;
    rf.rsv_addr = '0;
  endtask

  task automatic set_wr(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
    rf.wr_en[k]            = 1'b1;
    rf.wr_addr[k*AW +: AW] = a;
    rf.wr_data[k*DW +: DW] = d;
  endtask

  task automatic set_rd(input int j, input logic [AW-1:0] a);
    rf.rd_addr[j*AW +: AW] = a;
  endtask

  function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
    logic [DW-1:0] r;
    r = '0;
    if (m_ready && a != '0) begin
      r = m_mem[a];
`ifdef MP_REGFILE_BYPASS_EN
      for (int k = 0; k < NW; k++)
        if (rf.wr_en[k] && rf.wr_addr[k*AW +: AW] == a) r = rf.wr_data[k*DW +: DW];
`endif
    end
    return r;
  endfunction

  function automatic logic exp_pend(input logic [AW-1:0] a);
    logic r;
    r = 1'b0;
    if (m_ready && a != '0) begin
      r = m_pend[a];
`ifdef MP_REGFILE_BYPASS_EN
      for (int k = 0; k < NW; k++)
        if (rf.wr_en[k] && rf.wr_addr[k*AW +: AW] == a) r = rf.rsv_en && (rf.rsv_addr == a);
`endif
    end
    return r;
  endfunction

  // Check outputs mid-cycle, then advance the model by one clock edge.
  task automatic cycle();
    logic [AW-1:0] ra;
    @(negedge clk);
    chk("init_done", DW'(rf.init_done), DW'(m_ready));
    for (int j = 0; j < NR; j++) begin
      ra = rf.rd_addr[j*AW +: AW];
      chk($sformatf("rd_data[%0d]@%0d", j, ra), rf.rd_data[j*DW +: DW], exp_data(ra));
      chk($sformatf("rd_pending[%0d]@%0d", j, ra), DW'(rf.rd_pending[j]), DW'(exp_pend(ra)));
    end
    @(posedge clk);
    if (m_ready) begin
      for (int k = 0; k < NW; k++) begin
        if (rf.wr_en[k] && rf.wr_addr[k*AW +: AW] != '0) begin
          m_mem[rf.wr_addr[k*AW +: AW]]  = rf.wr_data[k*DW +: DW];
          m_pend[rf.wr_addr[k*AW +: AW]] = 1'b0;
        end
      end
      if (rf.rsv_en && rf.rsv_addr != '0) m_pend[rf.rsv_addr] = 1'b1;
    end else begin
      m_cnt++;
      if (m_cnt == NREG - 1) m_ready = 1'b1;
    end
    #1;
  endtask

  task automatic random_inputs(input int amax);
    rf.wr_en    = NW'($urandom);
    rf.rsv_en   = 1'($urandom);
    rf.rsv_addr = AW'($urandom_range(0, amax));
    for (int k = 0; k < NW; k++) begin
      rf.wr_addr[k*AW +: AW] = AW'($urandom_range(0, amax));
      rf.wr_data[k*DW +: DW] = $urandom;
    end
    for (int j = 0; j < NR; j++) begin
      if ($urandom_range(0, 1) == 1) set_rd(j, rf.wr_addr[($urandom_range(0, NW-1))*AW +: AW]);
      else set_rd(j, AW'($urandom_range(0, amax)));
    end
  endtask

  // Runs through INIT with ignored random traffic and checks its length.
  task automatic run_init(input string tag);
    int n_low;
    n_low = 0;
    for (int i = 0; i < 40; i++) begin
      if (i < NREG - 1) random_inputs(NREG - 1);
      else idle();
      if (rf.init_done === 1'b0) n_low++;
      cycle();
    end
    chk(tag, DW'(n_low), DW'(NREG - 1));
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    idle();
    rf.rd_addr = '0;
    m_reset();
    set_rd(0, 5'd1);
    #2;
    chk("reset_init_done", DW'(rf.init_done), '0);
    chk("reset_rd_data", rf.rd_data[0 +: DW], '0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    run_init("init_low_cycles");

    idle();
    for (int a = 1; a < NREG; a += 2) begin
      set_rd(0, AW'(a));
      set_rd(1, AW'(a + 1 < NREG ? a + 1 : a));
      #1 chk($sformatf("cleared_r%0d", a), rf.rd_data[0 +: DW], '0);
      cycle();
    end

    set_wr(0, 5'd7, 32'hAAAA0000);
    set_wr(1, 5'd7, 32'h5555FFFF);
    cycle();
    idle();
    set_rd(0, 5'd7);
    #1 chk("same_addr_priority", rf.rd_data[0 +: DW], 32'h5555FFFF);
    cycle();

    set_wr(0, 5'd0, 32'hDEADBEEF);
    rf.rsv_en = 1'b1;
    rf.rsv_addr = 5'd0;
    cycle();
    idle();
    set_rd(0, 5'd0);
    #1 chk("r0_data", rf.rd_data[0 +: DW], '0);
    chk("r0_pending", DW'(rf.rd_pending[0]), '0);
    cycle();

    rf.rsv_en = 1'b1;
    rf.rsv_addr = 5'd5;
    cycle();
    idle();
    set_rd(0, 5'd5);
    #1 chk("rsv5_pending", DW'(rf.rd_pending[0]), 32'd1);
    set_wr(0, 5'd5, 32'h12);
    cycle();
    idle();
    #1 chk("wr5_clears_pending", DW'(rf.rd_pending[0]), '0);
    chk("wr5_data", rf.rd_data[0 +: DW], 32'h12);
    rf.rsv_en = 1'b1;
    rf.rsv_addr = 5'd5;
    set_wr(1, 5'd5, 32'h34);
    cycle();
    idle();
    #1 chk("rsv_beats_write", DW'(rf.rd_pending[0]), 32'd1);
    chk("rsv_write_data", rf.rd_data[0 +: DW], 32'h34);
    cycle();

    set_wr(0, 5'd9, 32'h1111);
    cycle();
    idle();
    set_wr(1, 5'd9, 32'hCAFE);
    set_rd(0, 5'd9);
`ifdef MP_REGFILE_BYPASS_EN
    #1 chk("bypass_same_cycle", rf.rd_data[0 +: DW], 32'hCAFE);
`else
    #1 chk("no_bypass_same_cycle", rf.rd_data[0 +: DW], 32'h1111);
`endif
    cycle();
    idle();
    #1 chk("write_next_cycle", rf.rd_data[0 +: DW], 32'hCAFE);
    cycle();

    for (int i = 0; i < 400; i++) begin
      random_inputs(7);
      cycle();
    end

    idle();
    set_wr(0, 5'd3, 32'h1);
    cycle();
    idle();
    set_rd(0, 5'd3);
    #1 chk("r3_before_reset", rf.rd_data[0 +: DW], 32'h1);
    rst_n = 1'b0;
    #2;
    chk("midreset_init_done", DW'(rf.init_done), '0);
    chk("midreset_rd_data", rf.rd_data[0 +: DW], '0);
    m_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    run_init("reinit_low_cycles");
    idle();
    set_rd(0, 5'd3);
    #1 chk("r3_after_reinit", rf.rd_data[0 +: DW], '0);
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
